// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Bus bundle between two requesters, the arbiter and a shared ALU.
//            The slave modport is the arbiter's view. The master modport is
//            the environment's view: both requesters plus the ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  // Requester 0 request channel
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_src_a;
  logic [DATA_W-1:0] req0_src_b;
  logic [3:0]        req0_op;
  // Requester 1 request channel
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_src_a;
  logic [DATA_W-1:0] req1_src_b;
  logic [3:0]        req1_op;
  // Response channel (payload shared by both responders)
  logic              resp0_valid;
  logic              resp0_ready;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_zero;
  logic              resp_err;
  // Shared ALU connection
  logic [DATA_W-1:0] alu_src_a;
  logic [DATA_W-1:0] alu_src_b;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_src_a, req0_src_b, req0_op,
    input  req1_valid, req1_src_a, req1_src_b, req1_op,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_result, resp_zero, resp_err,
    input  resp0_ready, resp1_ready,
    output alu_src_a, alu_src_b, alu_control,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_src_a, req0_src_b, req0_op,
    output req1_valid, req1_src_a, req1_src_b, req1_op,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_result, resp_zero, resp_err,
    output resp0_ready, resp1_ready,
    input  alu_src_a, alu_src_b, alu_control,
    output alu_result, alu_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter sharing one combinational ALU between two
//            requesters. One operation in flight: IDLE -> EXEC -> RESP.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int         DATA_W = 32,
  parameter logic [3:0] MAX_OP = 4'b1000
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q,  prio_d;   // requester favoured on contention
  logic              gnt_q,   gnt_d;    // requester currently being served
  logic [DATA_W-1:0] a_q,     a_d;
  logic [DATA_W-1:0] b_q,     b_d;
  logic [3:0]        op_q,    op_d;
  logic [DATA_W-1:0] res_q,   res_d;
  logic              zero_q,  zero_d;
  logic              err_q,   err_d;

  logic              gsel;
  logic              rdy0, rdy1, rv0, rv1;

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Next-state, grant selection, result capture and handshake outputs.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    gsel    = 1'b0;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    rv0     = 1'b0;
    rv1     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Contention resolved by prio_q, otherwise the lone valid requester.
        if (bus.req0_valid && bus.req1_valid) gsel = prio_q;
        else                                  gsel = bus.req1_valid;
        if (bus.req0_valid || bus.req1_valid) begin
          rdy0    = ~gsel;
          rdy1    = gsel;
          gnt_d   = gsel;
          a_d     = gsel ? bus.req1_src_a : bus.req0_src_a;
          b_d     = gsel ? bus.req1_src_b : bus.req0_src_b;
          op_d    = gsel ? bus.req1_op    : bus.req0_op;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Illegal codes complete normally with a forced zero result.
        if (op_q > MAX_OP) begin
          res_d  = '0;
          zero_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          res_d  = bus.alu_result;
          zero_d = bus.alu_zero;
          err_d  = 1'b0;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rv0 = ~gnt_q;
        rv1 = gnt_q;
        if (gnt_q ? bus.resp1_ready : bus.resp0_ready) begin
          prio_d  = ~gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.resp0_valid = rv0;
  assign bus.resp1_valid = rv1;
  assign bus.resp_result = res_q;
  assign bus.resp_zero   = zero_q;
  assign bus.resp_err    = err_q;
  // ALU inputs come only from registers so they never follow request inputs.
  assign bus.alu_src_a   = a_q;
  assign bus.alu_src_b   = b_q;
  assign bus.alu_control = op_q;

endmodule
`default_nettype wire
